// File: rtl/l2_mem_responder_if.sv
// ============================================================================
// l2_mem_responder_if : L2 request/response bus between dcache and backing store
// Rev 1.0
// ============================================================================
`default_nettype none

package l2_mem_pkg;
    typedef enum logic {
        LOAD  = 1'b0,
        STORE = 1'b1
    } memory_operation_e;
endpackage

interface l2_mem_responder_if #(
    parameter int XLEN = 32
) ();
    import l2_mem_pkg::*;

    logic [XLEN-1:0]   l2_req_address;
    memory_operation_e l2_req_type;
    logic              l2_req_valid;
    logic [XLEN-1:0]   l2_word_to_store;
    logic [XLEN-1:0]   l2_fetched_word;
    logic              l2_fetched_word_valid;

    modport master (
        output l2_req_address, l2_req_type, l2_req_valid, l2_word_to_store,
        input  l2_fetched_word, l2_fetched_word_valid
    );

    modport slave (
        input  l2_req_address, l2_req_type, l2_req_valid, l2_word_to_store,
        output l2_fetched_word, l2_fetched_word_valid
    );
endinterface

`default_nettype wire

// File: rtl/l2_mem_responder.sv
// ============================================================================
// l2_mem_responder : word RAM answering L2 requests after a fixed latency.
// Optional response jitter via macro L2_RESP_JITTER_EN. Rev 1.0
// ============================================================================
`default_nettype none

module l2_mem_responder #(
    parameter int              XLEN         = 32,
    parameter int              MEM_WORDS    = 1024,
    parameter int              READ_LATENCY = 4,
    parameter logic [XLEN-1:0] FILL_WORD    = 32'hABAC_0012
) (
    input  wire logic          clk,
    input  wire logic          reset_n,
    l2_mem_responder_if.slave  bus
);
    import l2_mem_pkg::*;

    localparam int         IDX_W    = $clog2(MEM_WORDS);
    localparam logic [7:0] C_LAT_M1 = 8'(READ_LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_e;

    state_e            r_state;
    logic [7:0]        r_cnt;
    logic              r_valid;
    logic [XLEN-1:0]   r_word;
    logic [XLEN-3:0]   r_addr;
    memory_operation_e r_type;
    logic [XLEN-1:0]   r_wdata;
    logic [MEM_WORDS-1:0] r_written;
    logic [XLEN-1:0]   r_mem [MEM_WORDS];

    logic [IDX_W-1:0]  w_idx;
    logic              w_in_range;
    logic              w_accept;
    logic              w_wr;
    logic [XLEN-1:0]   w_rd_word;
    logic [7:0]        w_jit;
    logic              w_unused_addr_lo;

    assign w_unused_addr_lo = ^bus.l2_req_address[1:0];
    assign w_idx            = r_addr[IDX_W-1:0];

    // Any captured address bit above the index field makes the access out of range.
    generate
        if (XLEN - 2 > IDX_W) begin : g_range_chk
            assign w_in_range = ~|r_addr[XLEN-3:IDX_W];
        end else begin : g_range_all
            assign w_in_range = 1'b1;
        end
    endgenerate

    assign w_accept  = (r_state == S_IDLE) && bus.l2_req_valid;
    assign w_wr      = (r_state == S_WAIT) && bus.l2_req_valid && (r_cnt == 8'd0)
                       && (r_type == STORE) && w_in_range;
    assign w_rd_word = (w_in_range && r_written[w_idx]) ? r_mem[w_idx] : FILL_WORD;

`ifdef L2_RESP_JITTER_EN
    logic [7:0] r_lfsr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_lfsr <= 8'hA5;
        end else if (w_accept) begin
            r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
        end
    end

    assign w_jit = {6'd0, r_lfsr[1:0]};
`else
    assign w_jit = 8'd0;
`endif

    // RAM contents are deliberately unreset; the written bits mask stale data.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[w_idx] <= r_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= 8'd0;
            r_valid   <= 1'b0;
            r_word    <= '0;
            r_addr    <= '0;
            r_type    <= LOAD;
            r_wdata   <= '0;
            r_written <= '0;
        end else begin
            r_valid <= 1'b0;
            r_word  <= '0;
            case (r_state)
                S_IDLE: begin
                    if (bus.l2_req_valid) begin
                        r_addr  <= bus.l2_req_address[XLEN-1:2];
                        r_type  <= bus.l2_req_type;
                        r_wdata <= bus.l2_word_to_store;
                        r_cnt   <= C_LAT_M1 + w_jit;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (!bus.l2_req_valid) begin
                        r_state <= S_IDLE;
                    end else if (r_cnt == 8'd0) begin
                        r_state <= S_RESP;
                        r_valid <= 1'b1;
                        if (r_type == LOAD) begin
                            r_word <= w_rd_word;
                        end
                        if (w_wr) begin
                            r_written[w_idx] <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.l2_fetched_word       = r_word;
    assign bus.l2_fetched_word_valid = r_valid;

endmodule

`default_nettype wire

// File: tb/tb_l2_mem_responder.sv
// ============================================================================
// tb_l2_mem_responder : directed table-driven bench for l2_mem_responder
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_l2_mem_responder;
    import l2_mem_pkg::*;

    localparam int          LAT  = 4;
    localparam logic [31:0] FILL = 32'hABAC_0012;
`ifdef L2_RESP_JITTER_EN
    localparam int          JIT  = 3;
`else
    localparam int          JIT  = 0;
`endif

    typedef struct {
        bit          st;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;

    logic clk;
    logic reset_n;
    int   n_vec;
    int   n_bad;
    vec_t tbl [18];
    int   lat_a [16];
    int   lat_b [16];

    l2_mem_responder_if #(.XLEN(32)) bus ();

    l2_mem_responder #(
        .XLEN(32), .MEM_WORDS(1024), .READ_LATENCY(LAT), .FILL_WORD(FILL)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_range(input string nm, input int v, input int lo, input int hi);
        n_vec++;
        if (v < lo || v > hi) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d..%0d", nm, v, lo, hi);
        end
    endtask

    task automatic drive(input bit st, input logic [31:0] addr, input logic [31:0] data);
        bus.l2_req_type      = st ? STORE : LOAD;
        bus.l2_req_address   = addr;
        bus.l2_word_to_store = data;
        bus.l2_req_valid     = 1'b1;
    endtask

    // Counts rising edges until the pulse is seen at a falling edge (bounded).
    task automatic wait_pulse(output int edges, output bit got);
        got   = 1'b0;
        edges = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.l2_fetched_word_valid === 1'b1) begin
                got   = 1'b1;
                edges = i;
                break;
            end
        end
    endtask

    task automatic xact(input string nm, input bit st, input logic [31:0] addr,
                        input logic [31:0] data, input logic [31:0] exp, output int lat);
        int e;
        bit got;
        @(negedge clk);
        drive(st, addr, data);
        wait_pulse(e, got);
        lat = e - 1;
        chk({nm, "_pulse"}, {31'd0, got}, 32'd1);
        if (got) begin
            chk_range({nm, "_lat"}, lat, LAT, LAT + JIT);
            chk({nm, "_data"}, bus.l2_fetched_word, exp);
        end
        bus.l2_req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk({nm, "_one_cycle"}, {31'd0, bus.l2_fetched_word_valid}, 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.l2_req_valid = 1'b0;
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        int lat, e, seen;
        bit got;
        n_vec = 0;
        n_bad = 0;
        tbl[0]  = '{1'b0, 32'h0000_0100, 32'h0,         FILL};
        tbl[1]  = '{1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0};
        tbl[2]  = '{1'b0, 32'h0000_0102, 32'h0,         32'hDEAD_BEEF};
        tbl[3]  = '{1'b1, 32'h0000_0040, 32'h1111_1111, 32'h0};
        tbl[4]  = '{1'b1, 32'h0000_0044, 32'h2222_2222, 32'h0};
        tbl[5]  = '{1'b1, 32'h0000_0048, 32'h3333_3333, 32'h0};
        tbl[6]  = '{1'b1, 32'h0000_004C, 32'h4444_4444, 32'h0};
        tbl[7]  = '{1'b1, 32'h8000_0000, 32'hCAFE_F00D, 32'h0};
        tbl[8]  = '{1'b0, 32'h8000_0000, 32'h0,         FILL};
        tbl[9]  = '{1'b0, 32'h0000_0000, 32'h0,         FILL};
        tbl[10] = '{1'b1, 32'h0000_0000, 32'h5555_5555, 32'h0};
        tbl[11] = '{1'b0, 32'h0000_1000, 32'h0,         FILL};
        tbl[12] = '{1'b0, 32'h0000_0000, 32'h0,         32'h5555_5555};
        tbl[13] = '{1'b0, 32'h0000_0FFC, 32'h0,         FILL};
        tbl[14] = '{1'b1, 32'h0000_0FFC, 32'h7777_7777, 32'h0};
        tbl[15] = '{1'b0, 32'h0000_0FFF, 32'h0,         32'h7777_7777};
        tbl[16] = '{1'b1, 32'h0000_0104, 32'h9999_AAAA, 32'h0};
        tbl[17] = '{1'b0, 32'h0000_0104, 32'h0,         32'h9999_AAAA};

        reset_n              = 1'b0;
        bus.l2_req_valid     = 1'b0;
        bus.l2_req_type      = LOAD;
        bus.l2_req_address   = '0;
        bus.l2_word_to_store = '0;
        repeat (3) @(negedge clk);
        chk("reset_valid", {31'd0, bus.l2_fetched_word_valid}, 32'd0);
        chk("reset_word", bus.l2_fetched_word, 32'd0);
        reset_n = 1'b1;

        for (int i = 0; i < 18; i++) begin
            xact($sformatf("vec%0d", i), tbl[i].st, tbl[i].addr, tbl[i].data, tbl[i].exp, lat);
        end

        // Line fill with valid held high, address advanced on each pulse.
        @(negedge clk);
        drive(1'b0, 32'h40, 32'h0);
        for (int k = 0; k < 4; k++) begin
            bus.l2_req_address = 32'h40 + 32'(4 * k);
            wait_pulse(e, got);
            chk($sformatf("fill%0d_pulse", k), {31'd0, got}, 32'd1);
            chk($sformatf("fill%0d_data", k), bus.l2_fetched_word, 32'h1111_1111 * 32'(k + 1));
            if (k == 0) chk_range("fill0_lat", e - 1, LAT, LAT + JIT);
            else        chk_range($sformatf("fill%0d_space", k), e, LAT + 2, LAT + 2 + JIT);
        end
        bus.l2_req_valid = 1'b0;
        @(negedge clk);

        // Abort: valid dropped two cycles after acceptance.
        drive(1'b1, 32'h200, 32'h1234_5678);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        bus.l2_req_valid = 1'b0;
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.l2_fetched_word_valid === 1'b1) seen++;
        end
        chk("abort_no_pulse", 32'(seen), 32'd0);
        xact("abort_load", 1'b0, 32'h200, 32'h0, FILL, lat);

        // Reset in the middle of WAIT discards written bits.
        xact("rst_st", 1'b1, 32'h100, 32'h0BAD_F00D, 32'h0, lat);
        @(negedge clk);
        drive(1'b0, 32'h104, 32'h0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("rst_wait_valid", {31'd0, bus.l2_fetched_word_valid}, 32'd0);
        bus.l2_req_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        xact("rst_load", 1'b0, 32'h100, 32'h0, FILL, lat);

        // Reset during RESP clears the outputs asynchronously.
        xact("rresp_st", 1'b1, 32'h108, 32'h3C3C_5A5A, 32'h0, lat);
        @(negedge clk);
        drive(1'b0, 32'h108, 32'h0);
        wait_pulse(e, got);
        chk("rresp_pulse", {31'd0, got}, 32'd1);
        chk("rresp_data", bus.l2_fetched_word, 32'h3C3C_5A5A);
        reset_n = 1'b0;
        #1;
        chk("rresp_valid_clr", {31'd0, bus.l2_fetched_word_valid}, 32'd0);
        chk("rresp_word_clr", bus.l2_fetched_word, 32'd0);
        bus.l2_req_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;

        // Latency sequence from reset, twice; must be in range and repeatable.
        do_reset();
        for (int i = 0; i < 16; i++) xact($sformatf("seqa%0d", i), 1'b0, 32'h0, 32'h0, FILL, lat_a[i]);
        do_reset();
        for (int i = 0; i < 16; i++) xact($sformatf("seqb%0d", i), 1'b0, 32'h0, 32'h0, FILL, lat_b[i]);
        for (int i = 0; i < 16; i++) chk($sformatf("seq_repeat%0d", i), 32'(lat_b[i]), 32'(lat_a[i]));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
